// File: rtl/rom_port_arbiter_pkg.sv
// Shared widths, types and helpers for the ROM read-port arbiter.
package rom_port_arbiter_pkg;

  localparam int unsigned ADDR_W        = 17;
  localparam int unsigned ADDR1_W       = ADDR_W + 1;
  localparam int unsigned DATA_W        = 24;
  localparam int unsigned DEPTH_DEFAULT = 76050;
  localparam int unsigned MAX_PORTS     = 4;
  localparam int unsigned PORT_W        = 2;
  localparam int unsigned WAIT_W        = 4;

  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [WAIT_W-1:0] wait_cnt_t;

  // Tracks one accepted read through the ROM's registered pipeline.
  typedef struct packed {
    logic      valid;
    port_idx_t port;
    logic      oor;
  } tag_t;

  function automatic port_idx_t next_port(input port_idx_t p, input int unsigned n);
    return (32'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester-side bus of the ROM arbiter: requests in, grants and tagged responses out.
interface rom_port_arbiter_if
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS = 4
) ();

  logic [N_PORTS-1:0]             req;
  logic [N_PORTS-1:0][ADDR_W-1:0] addr;
  logic [N_PORTS-1:0]             gnt;
  logic [N_PORTS-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_oor;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_oor
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rsp_valid,
    output rsp_data,
    output rsp_oor
  );

endinterface

// File: rtl/rom_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after start, wrapping.
module rom_port_arbiter_rr_pick
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  port_idx_t    start,
  output logic [N-1:0] onehot_c,
  output port_idx_t    idx_c
);

  logic found;

  // Two passes avoid a variable rotate: upper segment first, then the wrap.
  always_comb begin
    found    = 1'b0;
    idx_c    = '0;
    onehot_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (PORT_W'(i) >= start)) begin
        found = 1'b1;
        idx_c = PORT_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx_c = PORT_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      onehot_c[i] = found && (idx_c == PORT_W'(i));
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one registered-output ROM between up to four pixel requesters with
// round-robin, optional port-0 priority, starvation override and tagged returns.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS  = 4,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned PRIO0    = 1,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  rom_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data
);

  localparam wait_cnt_t         MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR1_W-1:0] DEPTH_C   = ADDR1_W'(DEPTH);
  localparam bit                PRIO0_EN   = (PRIO0 != 0);

  port_idx_t          rr_ptr_q, rr_ptr_d;
  wait_cnt_t          wait_q [1:N_PORTS-1];
  wait_cnt_t          wait_d [1:N_PORTS-1];
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  tag_t               tag1_q, tag1_d;
  tag_t               tag2_q, tag2_d;

  logic [N_PORTS-1:0] rr_onehot_c;
  port_idx_t          rr_idx_c;
  logic               force_any_c;
  port_idx_t          force_idx_c;
  port_idx_t          sel_idx_c;
  logic [N_PORTS-1:0] gnt_c;
  logic               xfer_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic               sel_oor_c;

  rom_port_arbiter_rr_pick #(
    .N (N_PORTS)
  ) u_rr_pick (
    .req      (bus.req),
    .start    (rr_ptr_q),
    .onehot_c (rr_onehot_c),
    .idx_c    (rr_idx_c)
  );

  // Grant selection: forced starving port, then port-0 priority, then round-robin.
  always_comb begin
    force_any_c = 1'b0;
    force_idx_c = '0;
    sel_idx_c   = rr_idx_c;
    gnt_c       = rr_onehot_c;
    for (int unsigned i = 1; i < N_PORTS; i++) begin
      if (PRIO0_EN && !force_any_c && bus.req[i] && (wait_q[i] == MAX_WAIT_C)) begin
        force_any_c = 1'b1;
        force_idx_c = PORT_W'(i);
      end
    end
    if (force_any_c) begin
      sel_idx_c = force_idx_c;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        gnt_c[i] = (force_idx_c == PORT_W'(i));
      end
    end else if (PRIO0_EN && bus.req[0]) begin
      sel_idx_c = '0;
      gnt_c     = N_PORTS'(1);
    end
    xfer_c = |gnt_c;
  end

  assign sel_addr_c = bus.addr[sel_idx_c];
  assign sel_oor_c  = ({1'b0, sel_addr_c} >= DEPTH_C);

  // Next-state for pointer, wait counters, ROM address and tag pipeline.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    tag1_d     = '0;
    tag2_d     = tag1_q;
    for (int unsigned i = 1; i < N_PORTS; i++) begin
      wait_d[i] = wait_q[i];
      if (!bus.req[i] || gnt_c[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != MAX_WAIT_C) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
    if (xfer_c) begin
      rr_ptr_d     = next_port(sel_idx_c, N_PORTS);
      rom_addr_d   = sel_oor_c ? '0 : sel_addr_c;
      tag1_d.valid = 1'b1;
      tag1_d.port  = sel_idx_c;
      tag1_d.oor   = sel_oor_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rom_addr_q <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      for (int unsigned i = 1; i < N_PORTS; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      for (int unsigned i = 1; i < N_PORTS; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  // Stage-2 tag lines up with the ROM's registered data.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      bus.rsp_valid[i] = tag2_q.valid && (tag2_q.port == PORT_W'(i));
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.rsp_data = rom_data;
  assign bus.rsp_oor  = tag2_q.valid & tag2_q.oor;
  assign rom_addr     = rom_addr_q;

endmodule
